// File: rtl/ts_null_stuffer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ts_null_stuffer_pkg
// Purpose : Shared constants, bank/write-state encodings and the null-packet
//           byte generator for the TS null stuffer.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ts_null_stuffer_pkg;

   localparam logic [7:0] TS_SYNC_BYTE    = 8'h47;
   localparam int         PKT_LEN_DEFAULT = 188;

   // Null header byte 3: not scrambled, payload only, continuity counter 0.
   localparam logic [7:0] NULL_HDR_BYTE3  = 8'h10;
   localparam logic [7:0] NULL_STUFF_BYTE = 8'hFF;

   typedef enum logic {
      BANK_EMPTY = 1'b0,
      BANK_FULL  = 1'b1
   } bank_state_t;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_ACTIVE  = 2'd1,
      WR_DISCARD = 2'd2
   } wr_state_t;

   // Byte at position idx of a null packet carrying the given PID.
   function automatic logic [7:0] null_byte(input logic [31:0] idx,
                                            input logic [12:0] pid);
      case (idx)
         32'd0:   null_byte = TS_SYNC_BYTE;
         32'd1:   null_byte = {3'b000, pid[12:8]};
         32'd2:   null_byte = pid[7:0];
         32'd3:   null_byte = NULL_HDR_BYTE3;
         default: null_byte = NULL_STUFF_BYTE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/ts_null_stuffer_ram.sv
`default_nettype none
// ============================================================================
// Module  : ts_pkt_bank_ram
// Purpose : Two-bank packet store, one write port and one registered read
//           port. Contents are never reset.
// Ports   : clk_i            - clock
//           we_i/waddr_i/wdata_i - write port
//           re_i/raddr_i     - read request, data on rdata_o next cycle
// Revision: 1.0 - initial release
// ============================================================================
module ts_pkt_bank_ram #(
   parameter int DEPTH  = 376,
   parameter int ADDR_W = 9
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [7:0]        wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [7:0]        rdata_o
);

   logic [7:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem_q[raddr_i];
   end

endmodule
`default_nettype wire

// File: rtl/ts_null_stuffer.sv
`default_nettype none
// ============================================================================
// Module  : ts_null_stuffer
// Purpose : Ping-pong buffers incoming TS packets and replays them at the
//           rate of BYTE_TICK, inserting null packets when no full packet is
//           ready at a packet boundary.
// Ports   : CLK, RST (async, active low)
//           DATA_IN/DVALID_IN/PSYNC_IN - input TS byte stream
//           BYTE_TICK                  - output byte slot request
//           DATA_OUT/DVALID_OUT/PSYNC_OUT - constant-rate TS output
//           OVERFLOW                   - pulse per dropped input packet
//           NULL_COUNT/DROP_COUNT      - saturating statistics
// Revision: 1.0 - initial release
// ============================================================================
module ts_null_stuffer
   import ts_null_stuffer_pkg::*;
#(
   parameter logic [12:0] NULL_PID = 13'h1FFF,
   parameter int          PKT_LEN  = PKT_LEN_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  DATA_IN,
   input  logic        DVALID_IN,
   input  logic        PSYNC_IN,
   input  logic        BYTE_TICK,
   output logic [7:0]  DATA_OUT,
   output logic        DVALID_OUT,
   output logic        PSYNC_OUT,
   output logic        OVERFLOW,
   output logic [15:0] NULL_COUNT,
   output logic [7:0]  DROP_COUNT
);

   localparam int IDX_W  = $clog2(PKT_LEN);
   localparam int ADDR_W = $clog2(2 * PKT_LEN);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PKT_LEN - 1);
   localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(PKT_LEN);

   // Banks are filled and drained strictly alternately, so a single toggling
   // pointer per side always names the oldest-free (write) and oldest-full
   // (read) bank.
   bank_state_t      bank_q [2];
   bank_state_t      bank_d [2];
   wr_state_t        wr_state_q, wr_state_d;
   logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic             overflow_q, overflow_d;
   logic [7:0]       drop_cnt_q;

   logic [IDX_W-1:0] rd_idx_q;
   logic             rd_ptr_q;
   logic             src_bank_q;
   logic [15:0]      null_cnt_q;
   logic             s1_valid_q, s1_psync_q, s1_null_q;
   logic [7:0]       s1_byte_q;
   logic             dvalid_q, psync_q;
   logic [7:0]       data_q;

   logic             w_ram_we, w_wr_fill;
   logic [IDX_W-1:0] w_wr_idx;
   logic             w_rd_idx0, w_rd_last, w_src_bank, w_rd_free;
   logic [7:0]       w_ram_rdata;
   logic [ADDR_W-1:0] w_waddr, w_raddr;

   // ---------------------------------------------------------------- write
   always_comb begin
      wr_state_d = wr_state_q;
      wr_idx_d   = wr_idx_q;
      wr_ptr_d   = wr_ptr_q;
      overflow_d = 1'b0;
      w_ram_we   = 1'b0;
      w_wr_fill  = 1'b0;
      w_wr_idx   = wr_idx_q;
      if (DVALID_IN) begin
         if (PSYNC_IN) begin
            if (DATA_IN != TS_SYNC_BYTE) begin
               wr_state_d = WR_DISCARD;
            end else if (wr_state_q == WR_ACTIVE || bank_q[wr_ptr_q] == BANK_EMPTY) begin
               // A restart mid-packet reuses the bank already being written.
               w_ram_we   = 1'b1;
               w_wr_idx   = '0;
               wr_idx_d   = IDX_W'(1);
               wr_state_d = WR_ACTIVE;
            end else begin
               overflow_d = 1'b1;
               wr_state_d = WR_DISCARD;
            end
         end else if (wr_state_q == WR_ACTIVE) begin
            w_ram_we = 1'b1;
            if (wr_idx_q == LAST_IDX) begin
               w_wr_fill  = 1'b1;
               wr_idx_d   = '0;
               wr_ptr_d   = ~wr_ptr_q;
               wr_state_d = WR_IDLE;
            end else begin
               wr_idx_d = wr_idx_q + 1'b1;
            end
         end
      end
   end

   // Fill and free always target different banks, so both can apply at once.
   always_comb begin
      bank_d = bank_q;
      if (w_wr_fill) bank_d[wr_ptr_q] = BANK_FULL;
      if (w_rd_free) bank_d[rd_ptr_q] = BANK_EMPTY;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_state_q <= WR_IDLE;
         wr_idx_q   <= '0;
         wr_ptr_q   <= 1'b0;
         bank_q     <= '{BANK_EMPTY, BANK_EMPTY};
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         wr_idx_q   <= wr_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         bank_q     <= bank_d;
         overflow_q <= overflow_d;
         if (overflow_d && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 1'b1;
      end
   end

   // ----------------------------------------------------------------- read
   always_comb begin
      w_rd_idx0  = (rd_idx_q == '0);
      w_rd_last  = (rd_idx_q == LAST_IDX);
      // Source is decided from the registered full flags at index 0 only.
      w_src_bank = w_rd_idx0 ? (bank_q[rd_ptr_q] == BANK_FULL) : src_bank_q;
      w_rd_free  = BYTE_TICK & w_src_bank & w_rd_last;
   end

   assign w_waddr = (wr_ptr_q ? BANK1_BASE : '0) + ADDR_W'(w_wr_idx);
   assign w_raddr = (rd_ptr_q ? BANK1_BASE : '0) + ADDR_W'(rd_idx_q);

   ts_pkt_bank_ram #(
      .DEPTH  (2 * PKT_LEN),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk_i   (CLK),
      .we_i    (w_ram_we),
      .waddr_i (w_waddr),
      .wdata_i (DATA_IN),
      .re_i    (BYTE_TICK & w_src_bank),
      .raddr_i (w_raddr),
      .rdata_o (w_ram_rdata)
   );

   // Stage 1 runs alongside the RAM read so null and bank bytes share the
   // same two-cycle latency.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rd_idx_q   <= '0;
         rd_ptr_q   <= 1'b0;
         src_bank_q <= 1'b0;
         null_cnt_q <= '0;
         s1_valid_q <= 1'b0;
         s1_psync_q <= 1'b0;
         s1_null_q  <= 1'b0;
         s1_byte_q  <= '0;
         dvalid_q   <= 1'b0;
         psync_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         if (BYTE_TICK) begin
            rd_idx_q   <= w_rd_last ? '0 : rd_idx_q + 1'b1;
            src_bank_q <= w_src_bank;
            if (w_rd_free) rd_ptr_q <= ~rd_ptr_q;
            if (w_rd_idx0 && !w_src_bank && null_cnt_q != 16'hFFFF)
               null_cnt_q <= null_cnt_q + 1'b1;
            s1_psync_q <= w_rd_idx0;
            s1_null_q  <= ~w_src_bank;
            s1_byte_q  <= null_byte(32'(rd_idx_q), NULL_PID);
         end
         s1_valid_q <= BYTE_TICK;
         dvalid_q   <= s1_valid_q;
         psync_q    <= s1_valid_q & s1_psync_q;
         if (s1_valid_q) data_q <= s1_null_q ? s1_byte_q : w_ram_rdata;
      end
   end

   assign DATA_OUT   = data_q;
   assign DVALID_OUT = dvalid_q;
   assign PSYNC_OUT  = psync_q;
   assign OVERFLOW   = overflow_q;
   assign NULL_COUNT = null_cnt_q;
   assign DROP_COUNT = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_null_stuffer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ts_null_stuffer
// Purpose : Self-checking bench for ts_null_stuffer. A queue-based model of
//           the buffer predicts every output byte, overflow pulse and counter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ts_null_stuffer;

   localparam int L = 188;

   logic        CLK, RST;
   logic [7:0]  DATA_IN;
   logic        DVALID_IN, PSYNC_IN, BYTE_TICK;
   logic [7:0]  DATA_OUT;
   logic        DVALID_OUT, PSYNC_OUT, OVERFLOW;
   logic [15:0] NULL_COUNT;
   logic [7:0]  DROP_COUNT;

   ts_null_stuffer dut (
      .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DVALID_IN(DVALID_IN),
      .PSYNC_IN(PSYNC_IN), .BYTE_TICK(BYTE_TICK), .DATA_OUT(DATA_OUT),
      .DVALID_OUT(DVALID_OUT), .PSYNC_OUT(PSYNC_OUT), .OVERFLOW(OVERFLOW),
      .NULL_COUNT(NULL_COUNT), .DROP_COUNT(DROP_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- model
   typedef struct { int cyc; logic [7:0] d; logic ps; } exp_t;
   exp_t       exp_q [$];
   int         ovf_q [$];
   logic [7:0] fifo  [$];   // completed packets, concatenated
   logic [7:0] rx    [$];   // packet under reception
   bit         rx_on = 0;
   int         m_idx = 0;
   bit         m_src_bank = 0;
   int         m_null = 0;
   int         m_drop = 0;
   int         cyc = 0;
   logic [7:0] last_data = 8'h00;

   function automatic logic [7:0] null_ref(input int i);
      case (i)
         0:       return 8'h47;
         1:       return 8'h1F;
         2:       return 8'hFF;
         3:       return 8'h10;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic model_clear();
      exp_q.delete(); ovf_q.delete(); fifo.delete(); rx.delete();
      rx_on = 0; m_idx = 0; m_src_bank = 0; m_null = 0; m_drop = 0;
      last_data = 8'h00;
   endtask

   task automatic model_step();
      int sz0;
      logic [7:0] b;
      bit pop, done;
      sz0 = fifo.size() / L;
      pop = 0; done = 0;
      if (BYTE_TICK) begin
         if (m_idx == 0) begin
            m_src_bank = (sz0 > 0);
            if (!m_src_bank && m_null != 65535) m_null++;
         end
         b = m_src_bank ? fifo[m_idx] : null_ref(m_idx);
         exp_q.push_back('{cyc + 1, b, (m_idx == 0)});
         if (m_idx == L - 1) begin
            pop = m_src_bank;
            m_idx = 0;
         end else m_idx++;
      end
      if (DVALID_IN) begin
         if (PSYNC_IN) begin
            if (DATA_IN != 8'h47) rx_on = 0;
            else if (rx_on || sz0 < 2) begin
               rx.delete(); rx.push_back(DATA_IN); rx_on = 1;
            end else begin
               rx_on = 0; ovf_q.push_back(cyc);
               if (m_drop != 255) m_drop++;
            end
         end else if (rx_on) begin
            rx.push_back(DATA_IN);
            if (rx.size() == L) begin done = 1; rx_on = 0; end
         end
      end
      if (pop) repeat (L) void'(fifo.pop_front());
      if (done) begin
         foreach (rx[i]) fifo.push_back(rx[i]);
         rx.delete();
      end
   endtask

   always @(posedge CLK) begin
      cyc = cyc + 1;
      if (!RST) model_clear();
      else model_step();
   end

   // ----------------------------------------------------------- monitor
   always @(posedge CLK) begin
      #4;
      if (RST) begin
         bit due, ovf_due;
         exp_t e;
         due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
         chk("dvalid_out", 32'(DVALID_OUT), 32'(due));
         if (due) begin
            e = exp_q.pop_front();
            chk("data_out", 32'(DATA_OUT), 32'(e.d));
            chk("psync_out", 32'(PSYNC_OUT), 32'(e.ps));
            last_data = e.d;
         end else begin
            chk("psync_idle", 32'(PSYNC_OUT), 32'd0);
            chk("data_hold", 32'(DATA_OUT), 32'(last_data));
         end
         ovf_due = (ovf_q.size() > 0) && (ovf_q[0] <= cyc);
         if (ovf_due) void'(ovf_q.pop_front());
         chk("overflow", 32'(OVERFLOW), 32'(ovf_due));
         chk("null_count", 32'(NULL_COUNT), 32'(m_null));
         chk("drop_count", 32'(DROP_COUNT), 32'(m_drop));
      end
   end

   // ---------------------------------------------------------- stimulus
   task automatic step(input logic dv, input logic ps, input logic [7:0] d, input logic tk);
      DVALID_IN = dv; PSYNC_IN = ps; DATA_IN = d; BYTE_TICK = tk;
      @(posedge CLK);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic align_idx0();
      for (int i = 0; i < L && m_idx != 0; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
   endtask

   task automatic send_pkt(input logic [7:0] first, input int nbytes, input bit pattern);
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         if (i == 0)        b = first;
         else if (!pattern) b = 8'($urandom);
         else if (i == 1)   b = 8'h41;
         else if (i == 2)   b = 8'h00;
         else if (i == 3)   b = 8'h10;
         else               b = 8'(i - 4);
         step(1'b1, (i == 0), b, 1'b0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_data"},   32'(DATA_OUT),   32'd0);
      chk({tag, "_dvalid"}, 32'(DVALID_OUT), 32'd0);
      chk({tag, "_psync"},  32'(PSYNC_OUT),  32'd0);
      chk({tag, "_ovf"},    32'(OVERFLOW),   32'd0);
      chk({tag, "_nullc"},  32'(NULL_COUNT), 32'd0);
      chk({tag, "_dropc"},  32'(DROP_COUNT), 32'd0);
   endtask

   initial begin
      int pos, pct;
      logic dv, ps;
      logic [7:0] d;
      RST = 1'b0; DATA_IN = '0; DVALID_IN = 0; PSYNC_IN = 0; BYTE_TICK = 0;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_values("por");
      RST = 1'b1;
      step(0, 0, 8'h00, 0);

      // Two null packets with no input.
      ticks(2 * L);
      step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
      chk("null_count_two", 32'(NULL_COUNT), 32'd2);

      // One patterned packet replayed byte-exact.
      send_pkt(8'h47, L, 1'b1);
      ticks(L);

      // Three back-to-back packets: third dropped, first two replayed.
      send_pkt(8'h47, L, 1'b0);
      send_pkt(8'h47, L, 1'b0);
      send_pkt(8'h47, L, 1'b0);
      step(0, 0, 8'h00, 0);
      chk("drop_count_one", 32'(DROP_COUNT), 32'd1);
      ticks(2 * L);

      // Sync at write index 100 restarts; new packet intact.
      send_pkt(8'h47, 100, 1'b1);
      send_pkt(8'h47, L, 1'b1);
      ticks(L);
      chk("drop_after_restart", 32'(DROP_COUNT), 32'd1);

      // Bad sync byte: packet ignored, null emitted.
      send_pkt(8'h48, L, 1'b0);
      ticks(L);

      // Randomised traffic at several output rates.
      pos = 0;
      for (int ch = 0; ch < 3; ch++) begin
         pct = (ch == 0) ? 100 : (ch == 1) ? 93 : 70;
         for (int c = 0; c < 6000; c++) begin
            dv = ($urandom_range(0, 3) != 0);
            ps = 1'b0;
            d  = 8'($urandom);
            if (dv) begin
               if (pos == 0 || $urandom_range(0, 299) == 0) begin
                  ps  = 1'b1;
                  d   = ($urandom_range(0, 19) == 0) ? 8'h48 : 8'h47;
                  pos = 1;
               end else begin
                  pos++;
                  if (pos == L) pos = 0;
               end
            end
            step(dv, ps, d, ($urandom_range(0, 99) < pct));
         end
      end
      ticks(3 * L);
      align_idx0();

      // Drop counter saturation.
      send_pkt(8'h47, L, 1'b0);
      send_pkt(8'h47, L, 1'b0);
      for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 8'h47, 1'b0);
      step(0, 0, 8'h00, 0);
      chk("drop_saturated", 32'(DROP_COUNT), 32'd255);
      ticks(3 * L);
      align_idx0();

      // Reset at output index 50 with a partial packet pending.
      send_pkt(8'h47, L, 1'b1);
      send_pkt(8'h47, 30, 1'b0);
      ticks(50);
      RST = 1'b0;
      model_clear();
      #1;
      check_reset_values("async_rst");
      step(0, 0, 8'h00, 1'b1);
      step(0, 0, 8'h00, 1'b1);
      RST = 1'b1;
      #1;
      check_reset_values("post_rst");
      step(0, 0, 8'h00, 0);
      ticks(2 * L);
      step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0); step(0, 0, 8'h00, 0);
      chk("null_after_rst", 32'(NULL_COUNT), 32'd2);

      repeat (4) step(0, 0, 8'h00, 0);
      chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ts_null_stuffer.md
TS_NULL_STUFFER -- requirements
Module: ts_null_stuffer

Interface
REQ-001 SHALL have parameter NULL_PID, default 13'h1FFF, PID carried by inserted null packets.
REQ-002 SHALL have parameter PKT_LEN, default 188, TS packet length in bytes.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port DATA_IN  input  8  TS bytes from the T2-MI-over-TS packer.
REQ-006 SHALL have port DVALID_IN  input  1  DATA_IN valid this cycle.
REQ-007 SHALL have port PSYNC_IN  input  1  qualifies first byte of a packet; meaningful only with DVALID_IN.
REQ-008 SHALL have port BYTE_TICK  input  1  output byte slot request from the external rate generator; at most one per cycle.
REQ-009 SHALL have port DATA_OUT  output  8  constant-rate TS byte.
REQ-010 SHALL have port DVALID_OUT  output  1  DATA_OUT valid.
REQ-011 SHALL have port PSYNC_OUT  output  1  first byte of output packet.
REQ-012 SHALL have port OVERFLOW  output  1  one-cycle pulse per dropped input packet.
REQ-013 SHALL have port NULL_COUNT  output  16  saturating count of inserted null packets.
REQ-014 SHALL have port DROP_COUNT  output  8  saturating count of dropped input packets.

Function
REQ-015 SHALL buffer input in two PKT_LEN-byte banks (ping-pong), each flagged empty/full.
REQ-016 Write side: DVALID_IN&PSYNC_IN with DATA_IN=0x47 starts a packet in the oldest-free empty bank, write index 0; non-0x47 sync byte discards the packet until next PSYNC_IN.
REQ-017 Write index SHALL advance only on DVALID_IN; writing byte PKT_LEN-1 sets the bank full on the next edge.
REQ-018 PSYNC_IN arriving mid-packet SHALL abandon the partial packet (bank stays empty) and restart at index 0 in that bank.
REQ-019 PSYNC_IN with both banks full SHALL drop the whole packet, pulse OVERFLOW one cycle, increment DROP_COUNT.
REQ-020 Read side: output index 0..PKT_LEN-1 advances on each BYTE_TICK and wraps to 0.
REQ-021 At index 0 the source SHALL be chosen: oldest full bank if any (FIFO order), else null packet; choice holds for the whole packet.
REQ-022 Null packet bytes SHALL be 0x47, {3'b000,NULL_PID[12:8]}, NULL_PID[7:0], 0x10, then 0xFF for the remaining PKT_LEN-4 bytes; NULL_COUNT increments at its index 0.
REQ-023 Bank SHALL return to empty on the edge after its last byte is read.
REQ-024 DATA_OUT/DVALID_OUT/PSYNC_OUT SHALL be registered, valid exactly 2 cycles after BYTE_TICK (1 RAM read + 1 output register), for both bank and null sources.
REQ-025 DVALID_OUT SHALL be high for one cycle per BYTE_TICK, low otherwise; DATA_OUT holds last value when DVALID_OUT low.
REQ-026 PSYNC_OUT SHALL be high only with DVALID_OUT on output index 0.
REQ-027 Full flags are registered: a bank completing in the same cycle as an index-0 tick SHALL NOT be selected for that slot.
REQ-028 Simultaneous bank-free and bank-fill on one edge SHALL both take effect.
REQ-029 Counters SHALL saturate at all-ones, never wrap.

Reset
REQ-030 RST low SHALL asynchronously clear: banks empty, write/read indices 0, write idle, DATA_OUT 0, DVALID_OUT 0, PSYNC_OUT 0, OVERFLOW 0, NULL_COUNT 0, DROP_COUNT 0.
REQ-031 Reset mid-packet SHALL discard all buffered and partial data; first tick after release starts a packet (null unless a full packet arrived first).
REQ-032 RAM contents SHALL need no reset.

Structure
REQ-033 Shared package SHALL hold TS_SYNC_BYTE (0x47), default PKT_LEN, null header constants, bank-state encoding.
REQ-034 One sub-module ts_pkt_bank_ram: dual-port 2*PKT_LEN x 8, one write port, one registered read port.

Verification
REQ-035 No input, BYTE_TICK every cycle for 376 cycles -> two null packets: 47 1F FF 10 FF.., PSYNC_OUT on bytes 0 and 188, NULL_COUNT=2.
REQ-036 One valid packet (47 41 00 10, payload 00..B7) before tick index 0 -> output is that packet byte-exact, 2-cycle latency, NULL_COUNT=0.
REQ-037 Three back-to-back packets, BYTE_TICK idle -> third dropped, OVERFLOW one pulse, DROP_COUNT=1; ticks then emit packets 1,2 in order.
REQ-038 PSYNC_IN at write index 100 -> partial discarded, new packet output intact, DROP_COUNT=0.
REQ-039 First byte 0x48 with PSYNC_IN -> packet ignored, null emitted in its slot.
REQ-040 RST low at output index 50 -> all outputs 0 within same cycle; post-release first packet null, counters 0.
